// File: rtl/binconv_pkg.sv
// Shared types, field positions and helpers for the binary 3x3 stream convolution engine.
package binconv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FILL,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [7:0] SENTINEL = 8'hFF;
    localparam int N_MSB = 4;
    localparam int K_MSB = 8;
    localparam int T_LSB = 9;
    localparam int T_MSB = 12;
    localparam int KSIZE = 3;

    function automatic logic [3:0] popcnt9(input logic [8:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 9; i++) cnt = cnt + {3'd0, v[i]};
        return cnt;
    endfunction

endpackage

// File: rtl/binconv_pe.sv
// One output column: XNOR the 3x3 window against the kernel and compare the match count with T.
module binconv_pe
    import binconv_pkg::*;
(
    input  logic [8:0] win_i,
    input  logic [8:0] kern_i,
    input  logic [3:0] thr_i,
    output logic       bit_o
);

    logic [3:0] cnt;

    always_comb cnt = popcnt9(~(win_i ^ kern_i));

    assign bit_o = (cnt >= thr_i);

endmodule

// File: rtl/binconv_stream_engine.sv
// Streams headered bit-images from input SRAM, convolves each with its own 3x3 binary kernel
// and threshold, and packs the output rows contiguously into output SRAM until a sentinel header.
module binconv_stream_engine
    import binconv_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int IN_BASE   = 0,
    parameter int OUT_BASE  = 0,
    parameter int WMEM_BASE = 1
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              dut_err,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable
);

    localparam int OW = DATA_W - 2;

    state_e            state_q, state_d;
    logic              prime_q;
    logic [N_MSB:0]    n_q, rc_q;
    logic [K_MSB:0]    kern_q;
    logic [3:0]        thr_q;
    logic [DATA_W-1:0] r0_q, r1_q;
    logic [ADDR_W-1:0] raddr_q, waddr_q, wmaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q, err_q;

    logic [N_MSB:0]    hdr_n;
    logic              hdr_cyc, hdr_sent, hdr_legal, last_row;
    logic [OW-1:0]     obits;
    logic              unused_wmem;

    assign hdr_n     = sram_dut_read_data[N_MSB:0];
    assign hdr_sent  = (sram_dut_read_data[7:0] == SENTINEL);
    assign hdr_legal = !hdr_sent && (hdr_n >= 5'd3) && ({1'b0, hdr_n} <= 6'(DATA_W));
    // The first HDR cycle after a run only issues the header address; data arrives next cycle.
    assign hdr_cyc   = (state_q == S_HDR) && !prime_q;
    assign last_row  = (rc_q == n_q - 5'd1);
    assign unused_wmem = ^wmem_dut_read_data[DATA_W-1:T_MSB+1];

    // Window rows: r0_q = row k (top), r1_q = row k+1, live read data = row k+2 (bottom).
    for (genvar c = 0; c < OW; c++) begin : g_pe
        logic pe_bit;
        binconv_pe u_pe (
            .win_i  ({sram_dut_read_data[c+2:c], r1_q[c+2:c], r0_q[c+2:c]}),
            .kern_i (kern_q),
            .thr_i  (thr_q),
            .bit_o  (pe_bit)
        );
        assign obits[c] = pe_bit && (5'(c) <= n_q - 5'd3);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dut_run) state_d = S_HDR;
            S_HDR:   if (hdr_cyc) state_d = hdr_legal ? S_FILL : S_DONE;
            S_FILL:  if (rc_q == 5'd1) state_d = S_RUN;
            S_RUN:   if (last_row) state_d = S_HDR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dut_busy = (state_q == S_HDR) || (state_q == S_FILL) || (state_q == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            prime_q  <= 1'b0;
            n_q      <= '0;
            rc_q     <= '0;
            kern_q   <= '0;
            thr_q    <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wmaddr_q <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wen_q   <= (state_q == S_RUN);
            wdata_q <= (state_q == S_RUN) ? DATA_W'(obits) : '0;
            if (wen_q) waddr_q <= waddr_q + 1'b1;
            if (dut_busy) raddr_q <= raddr_q + 1'b1;
            case (state_q)
                S_IDLE: if (dut_run) begin
                    raddr_q  <= ADDR_W'(IN_BASE);
                    waddr_q  <= ADDR_W'(OUT_BASE);
                    wmaddr_q <= ADDR_W'(WMEM_BASE);
                    err_q    <= 1'b0;
                    prime_q  <= 1'b1;
                end
                S_HDR: begin
                    prime_q <= 1'b0;
                    if (hdr_cyc) begin
                        if (hdr_legal) begin
                            n_q      <= hdr_n;
                            kern_q   <= wmem_dut_read_data[K_MSB:0];
                            thr_q    <= wmem_dut_read_data[T_MSB:T_LSB];
                            wmaddr_q <= wmaddr_q + 1'b1;
                            rc_q     <= '0;
                        end else if (!hdr_sent) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_FILL, S_RUN: begin
                    r0_q <= r1_q;
                    r1_q <= sram_dut_read_data;
                    rc_q <= rc_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign dut_err                = err_q;
    assign dut_sram_read_address  = raddr_q;
    assign dut_wmem_read_address  = wmaddr_q;
    assign dut_sram_write_address = waddr_q;
    assign dut_sram_write_data    = wdata_q;
    assign dut_sram_write_enable  = wen_q;

endmodule
